pipe_stage: RTL and testbench

Parametrised elastic pipeline stage register for the five-stage core, the successor to the fixed-width per-stage flip-flop banks. It carries a control bundle and a data bundle between two stages under a valid/ready handshake and supports back-pressure (stall) and synchronous flush. Control bits read as zero whenever the stage holds no valid instruction, so downstream logic always sees a NOP bubble. Instantiated once per stage boundary (F/D, D/E, E/M, M/W) with per-boundary widths.

---
 rtl/pipe_stage.sv | 146 ++++++++++++++
 tb/tb_pipe_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready stage register with a NOP-gated control bundle.
// Define PIPE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage #(
    parameter int CTRL_W = 13,
    parameter int DATA_W = 165
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              load_main_s;
`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              load_skid_s;
    logic              main_from_skid_s;
    logic              in_ready_r;
`endif

    // Control reads as zero whenever no instruction is held, so a bubble is a NOP.
    assign out_valid = (state_r != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl_r : {CTRL_W{1'b0}};
    assign out_data  = main_data_r;

`ifdef PIPE_SKID_EN
    assign in_ready = in_ready_r;
`else
    assign in_ready = out_ready | ~out_valid;
`endif

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Next-state and load-select decode; flush wins over any transfer.
    always_comb begin
        state_nxt_s = state_r;
        load_main_s = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
`endif
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_HALF;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ST_HALF;
                        load_main_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_HALF;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_FULL: begin
                    if (out_xfer_s) begin
                        state_nxt_s      = ST_HALF;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
`endif
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers; reset clears every entry and overrides flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
`ifdef PIPE_SKID_EN
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b1;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (load_main_s) begin
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
`ifdef PIPE_SKID_EN
            end else if (main_from_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
`endif
            end else begin
                main_ctrl_r <= main_ctrl_r;
                main_data_r <= main_data_r;
            end
`ifdef PIPE_SKID_EN
            if (load_skid_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
                skid_data_r <= skid_data_r;
            end
            // Registered so out_ready never reaches in_ready combinationally.
            in_ready_r <= (state_nxt_s != ST_FULL);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: table vectors plus hand sequences, checked against a queue scoreboard.
// Handles both the default build and the PIPE_SKID_EN build.
module tb_pipe_stage;

    localparam int CW = 13;
    localparam int DW = 165;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    pipe_stage #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } word_t;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
    } vec_t;

    word_t q[$];
    vec_t  tbl[11];
    int    total = 0;
    int    bad   = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // One clock: compare outputs to the scoreboard, then advance the scoreboard.
    task automatic cycle();
        logic          exp_ir;
        logic          exp_ov;
        logic [CW-1:0] exp_c;
        bit            ix;
        bit            ox;
        word_t         w;
        #1;
        exp_ov = (q.size() > 0);
`ifdef PIPE_SKID_EN
        exp_ir = (q.size() < 2);
`else
        exp_ir = out_ready | ~exp_ov;
`endif
        exp_c = 13'h0;
        if (exp_ov) exp_c = q[0].c;
        if (chk_en) begin
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, exp_ov);
            check("out_ctrl", out_ctrl, exp_c);
            if (exp_ov) check("out_data", out_data, q[0].d);
        end
        ix = in_valid && exp_ir;
        ox = exp_ov && out_ready;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (ix) begin
                w.c = in_ctrl;
                w.d = in_data;
                q.push_back(w);
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [CW-1:0] c, input logic rdy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = DW'(32'hB000 + 32'(c));
        out_ready = rdy;
    endtask

    initial begin
        // Reset with a live all-ones word on the input.
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 13'h1FFF; in_data = {DW{1'b1}};
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, 13'h0);
        check("rst_out_data", out_data, {DW{1'b0}});
        check("rst_in_ready", in_ready, 1'b1);

        // Streaming words then bubbles with all-ones control on the input.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b1, CW'(i + 1), DW'(160 + i), 1'b1, CW'(i + 1), DW'(160 + i)};
        for (int i = 8; i < 11; i++)
            tbl[i] = '{1'b0, 1'b1, 13'h1FFF, {DW{1'b1}}, 1'b0, 13'h0, {DW{1'b0}}};
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            in_ctrl = tbl[i].c; in_data = tbl[i].d;
            cycle();
            check("tbl_out_valid", out_valid, tbl[i].ev);
            check("tbl_out_ctrl", out_ctrl, tbl[i].ec);
            if (tbl[i].ev) check("tbl_out_data", out_data, tbl[i].ed);
        end

`ifdef PIPE_SKID_EN
        // Stall: word 2 lands in the skid, word 3 waits upstream.
        offer(1'b1, 13'd1, 1'b1); cycle();
        offer(1'b1, 13'd2, 1'b0); cycle();
        #1 check("full_in_ready", in_ready, 1'b0);
        offer(1'b1, 13'd3, 1'b0); cycle(); cycle();
        offer(1'b1, 13'd3, 1'b1); cycle(); cycle();
        offer(1'b0, 13'd0, 1'b1); cycle(); cycle();
        check("stall_drained", out_valid, 1'b0);

        // Flush while FULL with word 7 offered: nothing survives.
        offer(1'b1, 13'd5, 1'b0); cycle();
        offer(1'b1, 13'd6, 1'b0); cycle();
        offer(1'b1, 13'd7, 1'b0); flush = 1'b1; cycle();
        flush = 1'b0;
        check("flush_full_valid", out_valid, 1'b0);
        check("flush_full_ctrl", out_ctrl, 13'h0);
        offer(1'b0, 13'd0, 1'b1); cycle(); cycle();
`else
        // Stall without skid: in_ready follows out_ready in the same cycle.
        offer(1'b1, 13'd1, 1'b1); cycle();
        offer(1'b1, 13'd2, 1'b0);
        #1 check("noskid_stall_ready", in_ready, 1'b0);
        cycle();
        offer(1'b1, 13'd2, 1'b1); cycle();
        check("noskid_reload_valid", out_valid, 1'b1);
        check("noskid_reload_ctrl", out_ctrl, 13'd2);
        offer(1'b0, 13'd0, 1'b1); cycle();

        // Flush while HALF and stalled.
        offer(1'b1, 13'd5, 1'b0); cycle();
        offer(1'b1, 13'd7, 1'b0); flush = 1'b1; cycle();
        flush = 1'b0;
        check("flush_half_valid", out_valid, 1'b0);
        check("flush_half_ctrl", out_ctrl, 13'h0);
        offer(1'b0, 13'd0, 1'b1); cycle();
`endif

        // Flush while delivering: held word counts as sent, offered word is dropped.
        offer(1'b1, 13'd9, 1'b1); cycle();
        offer(1'b1, 13'd10, 1'b1); flush = 1'b1; cycle();
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        offer(1'b0, 13'd0, 1'b1); cycle();

        // Reset mid-stall overrides a simultaneous flush and clears storage.
        offer(1'b1, 13'd11, 1'b0); cycle();
        offer(1'b1, 13'd12, 1'b0); cycle();
        reset = 1'b1; flush = 1'b1; cycle();
        reset = 1'b0; flush = 1'b0;
        check("rst_stall_valid", out_valid, 1'b0);
        check("rst_stall_data", out_data, {DW{1'b0}});
        offer(1'b0, 13'd0, 1'b1); cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
